demux2_buf: RTL and testbench

Buffered 1-to-2 demultiplexer with valid/ready handshakes: the distribution counterpart of the datapath 2:1 select. A single producer stream (e.g. writeback/result bus) is steered by a per-beat select bit to one of two consumers. Each consumer has its own 2-entry FIFO, so a stalled consumer blocks only beats addressed to it. Sits between the result source and two downstream sinks (e.g. register-file write port and forwarding/store path).

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux2_buf_fifo2.sv | 56 +++++
 rtl/demux2_buf.sv | 62 ++++++
 tb/tb_demux2_buf.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the buffered 1-to-2 demultiplexer.
package demux_pkg;

   localparam int DEPTH = 2;

   typedef logic [1:0] cnt_t;
   typedef logic       ptr_t;

   typedef enum logic {
      SEL_OUT0 = 1'b0,
      SEL_OUT1 = 1'b1
   } sel_e;

   localparam cnt_t CNT_EMPTY = 2'd0;
   localparam cnt_t CNT_FULL  = 2'd2;

endpackage

// File: rtl/demux2_buf_fifo2.sv
// Two-entry FIFO with registered head output; one per demux destination.
module fifo2
   import demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   cnt_t             r_cnt;
   ptr_t             r_rd_ptr;
   ptr_t             r_wr_ptr;
   logic             w_push;
   logic             w_pop;

   // Guard locally too, so a stray push on a full FIFO cannot overrun it.
   assign w_push = i_push & (r_cnt != CNT_FULL);
   assign w_pop  = i_pop  & (r_cnt != CNT_EMPTY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= CNT_EMPTY;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_valid = (r_cnt != CNT_EMPTY);
   assign o_full  = (r_cnt == CNT_FULL);
   assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/demux2_buf.sv
// Buffered 1-to-2 demultiplexer: steers each accepted beat into one of two
// independent 2-entry FIFOs so a stalled consumer only blocks its own beats.
module demux2_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             busy
);

   logic w_full0;
   logic w_full1;
   logic w_sel_full;
   logic w_accept;
   logic w_push0;
   logic w_push1;

   // Ready looks only at registered fullness and the select, never at the
   // consumer readies; it is held low while reset is asserted.
   assign w_sel_full = (in_sel == SEL_OUT1) ? w_full1 : w_full0;
   assign in_ready   = reset & ~w_sel_full;
   assign w_accept   = in_valid & in_ready;
   assign w_push0    = w_accept & (in_sel == SEL_OUT0);
   assign w_push1    = w_accept & (in_sel == SEL_OUT1);

   fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push0),
      .i_data  (in_data),
      .i_pop   (out0_ready),
      .o_valid (out0_valid),
      .o_data  (out0_data),
      .o_full  (w_full0)
   );

   fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push1),
      .i_data  (in_data),
      .i_pop   (out1_ready),
      .o_valid (out1_valid),
      .o_data  (out1_data),
      .o_full  (w_full1)
   );

   assign busy = out0_valid | out1_valid;

endmodule

// File: tb/tb_demux2_buf.sv
// Directed bench for demux2_buf with a per-output scoreboard queue model.
module tb_demux2_buf;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_sel;
   logic       out0_valid;
   logic       out0_ready;
   logic [7:0] out0_data;
   logic       out1_valid;
   logic       out1_ready;
   logic [7:0] out1_data;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   demux2_buf #(.WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic s);
      in_valid = v;
      in_data  = d;
      in_sel   = s;
   endtask

   // Called just after a falling edge: checks outputs against the model,
   // then advances the model by whatever the next rising edge will do.
   task automatic cycle();
      logic exp_rdy;
      logic acc;
      logic pop0;
      logic pop1;
      #1;
      exp_rdy = reset && (in_sel ? (q1.size() < 2) : (q0.size() < 2));
      chk("in_ready",   8'(in_ready),   8'(exp_rdy));
      chk("out0_valid", 8'(out0_valid), 8'(q0.size() != 0));
      chk("out1_valid", 8'(out1_valid), 8'(q1.size() != 0));
      chk("busy",       8'(busy),       8'((q0.size() != 0) || (q1.size() != 0)));
      if (q0.size() != 0)  chk("out0_data", out0_data, q0[0]);
      else if (!reset)     chk("out0_data_rst", out0_data, 8'h00);
      if (q1.size() != 0)  chk("out1_data", out1_data, q1[0]);
      else if (!reset)     chk("out1_data_rst", out1_data, 8'h00);
      acc  = in_valid && exp_rdy;
      pop0 = reset && out0_ready && (q0.size() != 0);
      pop1 = reset && out1_ready && (q1.size() != 0);
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (acc) begin
         if (in_sel) q1.push_back(in_data);
         else        q0.push_back(in_data);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset      = 1'b0;
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      drive(1'b1, 8'h55, 1'b0);
      @(negedge clk);

      // Reset held with a beat offered: nothing may be accepted.
      repeat (2) cycle();
      drive(1'b1, 8'h66, 1'b1);
      cycle();

      reset = 1'b1;
      drive(1'b0, 8'h00, 1'b0);
      cycle();

      // Steering
      drive(1'b1, 8'hA1, 1'b0); cycle();
      drive(1'b1, 8'hB2, 1'b1); cycle();
      drive(1'b0, 8'h00, 1'b0); repeat (2) cycle();

      // Backpressure isolation on out0
      out0_ready = 1'b0;
      drive(1'b1, 8'h10, 1'b0); cycle();
      drive(1'b1, 8'h11, 1'b0); cycle();
      drive(1'b1, 8'h12, 1'b0); cycle();
      drive(1'b1, 8'h20, 1'b1); cycle();
      drive(1'b0, 8'h00, 1'b0); cycle();
      out0_ready = 1'b1;
      repeat (3) cycle();

      // Full FIFO with simultaneous pop: offered push refused, then accepted
      out0_ready = 1'b0;
      drive(1'b1, 8'h30, 1'b0); cycle();
      drive(1'b1, 8'h31, 1'b0); cycle();
      out0_ready = 1'b1;
      drive(1'b1, 8'h32, 1'b0); cycle();
      cycle();
      drive(1'b0, 8'h00, 1'b0); repeat (3) cycle();

      // Streaming at one beat per cycle through out1
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 8'(i), 1'b1);
         cycle();
      end
      drive(1'b0, 8'h00, 1'b0); repeat (2) cycle();

      // Reset mid-stream with FIFO 0 full and FIFO 1 holding a beat
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      drive(1'b1, 8'h40, 1'b0); cycle();
      drive(1'b1, 8'h41, 1'b0); cycle();
      drive(1'b1, 8'h50, 1'b1); cycle();
      drive(1'b0, 8'h00, 1'b0);
      reset = 1'b0;
      #1;
      chk("rst_out0_valid", 8'(out0_valid), 8'h00);
      chk("rst_out1_valid", 8'(out1_valid), 8'h00);
      chk("rst_busy",       8'(busy),       8'h00);
      q0.delete();
      q1.delete();
      @(negedge clk);
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      cycle();
      reset = 1'b1;
      repeat (3) cycle();
      drive(1'b1, 8'h77, 1'b0); cycle();
      drive(1'b0, 8'h00, 1'b0); repeat (2) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
